// File: rtl/connect_pkg.sv
// Shared encodings for the Connect-N engine: FSM states, game status codes,
// and the per-direction row/col steps used by the run counter.
package connect_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_DROP  = 2'b01,
    ST_CHECK = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

  typedef enum logic [1:0] {
    GS_PLAYING = 2'b00,
    GS_P1_WIN  = 2'b01,
    GS_P2_WIN  = 2'b10,
    GS_DRAW    = 2'b11
  } status_e;

  typedef enum logic [1:0] {
    DIR_H = 2'd0,
    DIR_V = 2'd1,
    DIR_D = 2'd2,
    DIR_A = 2'd3
  } dir_e;

  // Row 0 is the bottom, so the anti-diagonal steps down as the column rises.
  localparam int DIR_DR [4] = '{0, 1, 1, -1};
  localparam int DIR_DC [4] = '{1, 0, 1,  1};

endpackage

// File: rtl/connect_n_engine_if.sv
// Move/display bus between the front end and the Connect-N engine.
// The undo line only exists when CONNECT_UNDO_EN is defined.
interface connect_n_engine_if #(
  parameter int ROWS = 4,
  parameter int COLS = 4
);
  logic                 enable;
  logic [COLS-1:0]      in_column;
`ifdef CONNECT_UNDO_EN
  logic                 undo;
`endif
  logic [ROWS*COLS-1:0] out_gameboard;
  logic [ROWS*COLS-1:0] out_players_cells;
  logic [1:0]           out_game_status;
  logic [1:0]           current_state;
  logic                 player_turn;
  logic                 move_reject;

  modport master (
    output enable, in_column,
`ifdef CONNECT_UNDO_EN
    output undo,
`endif
    input  out_gameboard, out_players_cells, out_game_status,
    input  current_state, player_turn, move_reject
  );

  modport slave (
    input  enable, in_column,
`ifdef CONNECT_UNDO_EN
    input  undo,
`endif
    output out_gameboard, out_players_cells, out_game_status,
    output current_state, player_turn, move_reject
  );
endinterface

// File: rtl/cn_run_counter.sv
// Combinational run length through one cell along one direction, counting
// same-owner neighbours on both sides (each side capped at WIN_LEN-1).
module cn_run_counter
  import connect_pkg::*;
#(
  parameter int ROWS    = 4,
  parameter int COLS    = 4,
  parameter int WIN_LEN = 4,
  parameter int HW      = $clog2(ROWS+1),
  parameter int CLW     = $clog2(COLS),
  parameter int RW      = $clog2(WIN_LEN*2)
) (
  input  logic [ROWS*COLS-1:0] board_i,
  input  logic [ROWS*COLS-1:0] owner_i,
  input  logic [HW-1:0]        row_i,
  input  logic [CLW-1:0]       col_i,
  input  dir_e                 dir_i,
  input  logic                 player_i,
  output logic [RW-1:0]        run_o
);
  localparam int CW = $clog2(ROWS*COLS);

  int   r, c, idx;
  logic go, inb;

  always_comb begin
    run_o = RW'(1);
    r     = 0;
    c     = 0;
    idx   = 0;
    go    = 1'b1;
    inb   = 1'b0;
    for (int s = 0; s < 2; s++) begin
      go = 1'b1;
      for (int k = 1; k < WIN_LEN; k++) begin
        r   = int'(row_i) + ((s == 0) ? k : -k) * DIR_DR[dir_i];
        c   = int'(col_i) + ((s == 0) ? k : -k) * DIR_DC[dir_i];
        inb = (r >= 0) && (r < ROWS) && (c >= 0) && (c < COLS);
        idx = inb ? (r * COLS + c) : 0;
        // Off-board or foreign/empty cells end this side's run.
        if (go && inb && board_i[idx[CW-1:0]] && (owner_i[idx[CW-1:0]] == player_i))
          run_o = run_o + RW'(1);
        else
          go = 1'b0;
      end
    end
  end
endmodule

// File: rtl/connect_n_engine.sv
// Connect-N game core: drop, four-cycle win check, draw/turn tracking.
// Define CONNECT_UNDO_EN for single-level undo of the last dropped move.
module connect_n_engine
  import connect_pkg::*;
#(
  parameter int ROWS    = 4,
  parameter int COLS    = 4,
  parameter int WIN_LEN = 4
) (
  input logic clk,
  input logic reset,
  connect_n_engine_if.slave bus
);
  localparam int HW  = $clog2(ROWS+1);
  localparam int MW  = $clog2(ROWS*COLS+1);
  localparam int CLW = $clog2(COLS);
  localparam int RW  = $clog2(WIN_LEN*2);
  localparam int CW  = $clog2(ROWS*COLS);
  localparam logic [HW-1:0] ROWS_H = HW'(ROWS);
  localparam logic [MW-1:0] CELLS  = MW'(ROWS*COLS);
  localparam logic [RW-1:0] WIN_R  = RW'(WIN_LEN);

  state_e                     state_q, state_d;
  status_e                    status_q, status_d;
  dir_e                       dir_q, dir_d;
  logic                       player_q, player_d;
  logic                       reject_q, reject_d;
  logic [ROWS*COLS-1:0]       board_q, board_d, owner_q, owner_d;
  logic [COLS-1:0][HW-1:0]    heights_q, heights_d;
  logic [MW-1:0]              moves_q, moves_d;
  logic [CLW-1:0]             col_q, col_d, sel_col;
  logic [HW-1:0]              row_q, row_d;
  logic                       sel_ok;
  logic [RW-1:0]              run;
  int                         pos;
`ifdef CONNECT_UNDO_EN
  logic                       last_vld_q, last_vld_d, last_player_q, last_player_d;
  logic [CLW-1:0]             last_col_q, last_col_d;
  logic [HW-1:0]              last_row_q, last_row_d;
  int                         lpos;
`endif

  assign sel_ok = $onehot(~bus.in_column);

  always_comb begin
    sel_col = '0;
    for (int c = 0; c < COLS; c++)
      if (!bus.in_column[c]) sel_col = CLW'(c);
  end

  cn_run_counter #(.ROWS(ROWS), .COLS(COLS), .WIN_LEN(WIN_LEN),
                   .HW(HW), .CLW(CLW), .RW(RW)) u_run (
    .board_i  (board_q),
    .owner_i  (owner_q),
    .row_i    (row_q),
    .col_i    (col_q),
    .dir_i    (dir_q),
    .player_i (player_q),
    .run_o    (run)
  );

  always_comb begin
    state_d   = state_q;
    status_d  = status_q;
    dir_d     = dir_q;
    player_d  = player_q;
    reject_d  = 1'b0;
    board_d   = board_q;
    owner_d   = owner_q;
    heights_d = heights_q;
    moves_d   = moves_q;
    col_d     = col_q;
    row_d     = row_q;
    pos       = int'(row_q) * COLS + int'(col_q);
`ifdef CONNECT_UNDO_EN
    last_vld_d    = last_vld_q;
    last_player_d = last_player_q;
    last_col_d    = last_col_q;
    last_row_d    = last_row_q;
    lpos          = int'(last_row_q) * COLS + int'(last_col_q);
`endif
    case (state_q)
      ST_IDLE: if (bus.enable) begin
        if (sel_ok && (heights_q[sel_col] < ROWS_H)) begin
          col_d   = sel_col;
          row_d   = heights_q[sel_col];
          state_d = ST_DROP;
        end else begin
          reject_d = 1'b1;
        end
      end
      ST_DROP: begin
        board_d[pos[CW-1:0]] = 1'b1;
        owner_d[pos[CW-1:0]] = player_q;
        heights_d[col_q]     = heights_q[col_q] + HW'(1);
        moves_d              = moves_q + MW'(1);
        dir_d                = DIR_H;
        state_d              = ST_CHECK;
`ifdef CONNECT_UNDO_EN
        last_vld_d    = 1'b1;
        last_player_d = player_q;
        last_col_d    = col_q;
        last_row_d    = row_q;
`endif
      end
      ST_CHECK: begin
        if (run >= WIN_R) begin
          status_d = player_q ? GS_P2_WIN : GS_P1_WIN;
          state_d  = ST_DONE;
        end else if (dir_q == DIR_A) begin
          if (moves_q == CELLS) begin
            status_d = GS_DRAW;
            state_d  = ST_DONE;
          end else begin
            player_d = ~player_q;
            state_d  = ST_IDLE;
          end
        end else begin
          dir_d = dir_e'(dir_q + 2'd1);
        end
      end
      default: ;
    endcase
`ifdef CONNECT_UNDO_EN
    // Undo overrides any same-cycle move request, including its reject pulse.
    if (bus.undo && last_vld_q && ((state_q == ST_IDLE) || (state_q == ST_DONE))) begin
      board_d[lpos[CW-1:0]] = 1'b0;
      owner_d[lpos[CW-1:0]] = 1'b0;
      heights_d[last_col_q] = heights_q[last_col_q] - HW'(1);
      moves_d               = moves_q - MW'(1);
      player_d              = last_player_q;
      status_d              = GS_PLAYING;
      state_d               = ST_IDLE;
      reject_d              = 1'b0;
      last_vld_d            = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      status_q  <= GS_PLAYING;
      dir_q     <= DIR_H;
      player_q  <= 1'b0;
      reject_q  <= 1'b0;
      board_q   <= '0;
      owner_q   <= '0;
      heights_q <= '0;
      moves_q   <= '0;
      col_q     <= '0;
      row_q     <= '0;
`ifdef CONNECT_UNDO_EN
      last_vld_q    <= 1'b0;
      last_player_q <= 1'b0;
      last_col_q    <= '0;
      last_row_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      status_q  <= status_d;
      dir_q     <= dir_d;
      player_q  <= player_d;
      reject_q  <= reject_d;
      board_q   <= board_d;
      owner_q   <= owner_d;
      heights_q <= heights_d;
      moves_q   <= moves_d;
      col_q     <= col_d;
      row_q     <= row_d;
`ifdef CONNECT_UNDO_EN
      last_vld_q    <= last_vld_d;
      last_player_q <= last_player_d;
      last_col_q    <= last_col_d;
      last_row_q    <= last_row_d;
`endif
    end
  end

  assign bus.out_gameboard     = board_q;
  assign bus.out_players_cells = owner_q;
  assign bus.out_game_status   = status_q;
  assign bus.current_state     = state_q;
  assign bus.player_turn       = player_q;
  assign bus.move_reject       = reject_q;
endmodule

// File: tb/tb_connect_n_engine.sv
// Directed bench for connect_n_engine on a 4x4 board, connect-4.
// Undo checks are compiled in only when CONNECT_UNDO_EN is defined.
module tb_connect_n_engine;
  logic clk = 1'b0;
  logic reset;
  int   n_run = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  connect_n_engine_if #(.ROWS(4), .COLS(4)) bus ();

  connect_n_engine #(.ROWS(4), .COLS(4), .WIN_LEN(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    bus.enable = 1'b0;
    bus.in_column = 4'hF;
    tick();
    reset = 1'b1;
  endtask

  function automatic logic [3:0] colsel(input int c);
    logic [3:0] v;
    v = 4'hF;
    v[c] = 1'b0;
    return v;
  endfunction

  // Issue one move and wait (bounded) for the engine to settle in IDLE/DONE.
  task automatic drop(input int c);
    int n;
    bus.enable = 1'b1;
    bus.in_column = colsel(c);
    tick();
    bus.enable = 1'b0;
    bus.in_column = 4'hF;
    n = 0;
    while (!(bus.current_state == 2'b00 || bus.current_state == 2'b11) && n < 10) begin
      tick();
      n++;
    end
    if (n >= 10) chk("move_timeout", n, 0);
  endtask

  initial begin
    int cols[11];
    reset = 1'b0;
    bus.enable = 1'b0;
    bus.in_column = 4'hF;
`ifdef CONNECT_UNDO_EN
    bus.undo = 1'b0;
`endif
    tick();
    tick();
    chk("por_state", bus.current_state, 2'b00);
    chk("por_board", bus.out_gameboard, 16'h0000);

    // Reset asserted mid-CHECK, with a move strobe on the same edge.
    reset = 1'b1;
    bus.enable = 1'b1;
    bus.in_column = 4'b1110;
    tick();
    bus.enable = 1'b0;
    tick();
    chk("pre_rst_state", bus.current_state, 2'b10);
    reset = 1'b0;
    bus.enable = 1'b1;
    tick();
    chk("rst_state", bus.current_state, 2'b00);
    chk("rst_board", bus.out_gameboard, 16'h0000);
    chk("rst_players", bus.out_players_cells, 16'h0000);
    chk("rst_status", bus.out_game_status, 2'b00);
    chk("rst_turn", bus.player_turn, 1'b0);
    chk("rst_reject", bus.move_reject, 1'b0);
    reset = 1'b1;
    bus.enable = 1'b0;
    bus.in_column = 4'hF;
    tick();
    chk("rst_after_state", bus.current_state, 2'b00);

    // Single drop: timing of DROP/CHECK/IDLE.
    bus.enable = 1'b1;
    bus.in_column = 4'b1110;
    tick();
    bus.enable = 1'b0;
    bus.in_column = 4'hF;
    chk("drop_state", bus.current_state, 2'b01);
    tick();
    chk("drop_board", bus.out_gameboard, 16'h0001);
    chk("drop_players", bus.out_players_cells, 16'h0000);
    chk("drop_check_state", bus.current_state, 2'b10);
    tick(); tick(); tick();
    chk("check_dir3_state", bus.current_state, 2'b10);
    tick();
    chk("drop_idle_state", bus.current_state, 2'b00);
    chk("drop_turn", bus.player_turn, 1'b1);

    // Vertical win for P1.
    do_reset();
    cols[0:6] = '{0, 1, 0, 1, 0, 1, 0};
    for (int i = 0; i < 7; i++) drop(cols[i]);
    chk("vwin_status", bus.out_game_status, 2'b01);
    chk("vwin_state", bus.current_state, 2'b11);
    chk("vwin_board", bus.out_gameboard, 16'h1333);
    chk("vwin_players", bus.out_players_cells, 16'h0222);
    chk("vwin_turn", bus.player_turn, 1'b0);
    bus.enable = 1'b1;
    bus.in_column = 4'b1011;
    tick();
    bus.enable = 1'b0;
    bus.in_column = 4'hF;
    chk("done_no_reject", bus.move_reject, 1'b0);
    tick();
    chk("done_board", bus.out_gameboard, 16'h1333);
    chk("done_state", bus.current_state, 2'b11);

    // Full column rejection.
    do_reset();
    for (int i = 0; i < 4; i++) drop(0);
    bus.enable = 1'b1;
    bus.in_column = 4'b1110;
    tick();
    bus.enable = 1'b0;
    bus.in_column = 4'hF;
    chk("full_reject", bus.move_reject, 1'b1);
    chk("full_state", bus.current_state, 2'b00);
    tick();
    chk("full_reject_end", bus.move_reject, 1'b0);
    chk("full_board", bus.out_gameboard, 16'h1111);
    chk("full_players", bus.out_players_cells, 16'h1010);
    chk("full_turn", bus.player_turn, 1'b0);

    // Malformed column selects.
    bus.enable = 1'b1;
    bus.in_column = 4'b1111;
    tick();
    chk("none_reject", bus.move_reject, 1'b1);
    bus.in_column = 4'b1100;
    tick();
    bus.enable = 1'b0;
    bus.in_column = 4'hF;
    chk("multi_reject", bus.move_reject, 1'b1);
    chk("multi_state", bus.current_state, 2'b00);
    tick();
    chk("multi_board", bus.out_gameboard, 16'h1111);
    chk("multi_turn", bus.player_turn, 1'b0);

    // Diagonal win; the last move is stepped by hand to see which cycle wins.
    do_reset();
    cols = '{0, 1, 1, 2, 2, 3, 2, 3, 3, 0, 3};
    for (int i = 0; i < 10; i++) drop(cols[i]);
    chk("diag_pre_status", bus.out_game_status, 2'b00);
    bus.enable = 1'b1;
    bus.in_column = colsel(3);
    tick();
    bus.enable = 1'b0;
    bus.in_column = 4'hF;
    tick(); tick(); tick();
    chk("diag_after_v_state", bus.current_state, 2'b10);
    tick();
    chk("diag_state", bus.current_state, 2'b11);
    chk("diag_status", bus.out_game_status, 2'b01);
    chk("diag_board", bus.out_gameboard, 16'h8CFF);
    chk("diag_players", bus.out_players_cells, 16'h009E);

`ifdef CONNECT_UNDO_EN
    bus.undo = 1'b1;
    tick();
    bus.undo = 1'b0;
    chk("undo_board", bus.out_gameboard, 16'h0CFF);
    chk("undo_status", bus.out_game_status, 2'b00);
    chk("undo_turn", bus.player_turn, 1'b0);
    chk("undo_state", bus.current_state, 2'b00);
    bus.undo = 1'b1;
    tick();
    bus.undo = 1'b0;
    chk("undo2_board", bus.out_gameboard, 16'h0CFF);
    chk("undo2_turn", bus.player_turn, 1'b0);
    drop(3);
    chk("redo_status", bus.out_game_status, 2'b01);
    chk("redo_board", bus.out_gameboard, 16'h8CFF);
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
